// File: rtl/layer2_weight_loader.sv
// Packs a one-weight-per-beat stream into node-wide words and writes them into latch-based layer-2 storage, node 0 first.
// Latency: WEIGHTS_PER_NODE+3 cycles per node (assemble, setup, write, hold), plus one DONE cycle after the last node.
// Backpressure: weightReady is high only while assembling. LAYER2_LOADER_CHECKSUM_EN adds a running 16-bit checksum output.
module layer2_weight_loader #(
  parameter int WEIGHT_WIDTH     = 8,
  parameter int WEIGHTS_PER_NODE = 10,
  parameter int RELU_NODES       = 64,
  parameter int RELU_INDEX_WIDTH = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [WEIGHT_WIDTH-1:0]                  weightIn,
  input  logic                                     weightValid,
  output logic                                     weightReady,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     writeEnable,
  output logic [RELU_INDEX_WIDTH-1:0]              NodeSelect,
  output logic [WEIGHTS_PER_NODE*WEIGHT_WIDTH-1:0] writeIn
`ifdef LAYER2_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                              checksum
`endif
);

  localparam int BEAT_W = (WEIGHTS_PER_NODE > 1) ? $clog2(WEIGHTS_PER_NODE) : 1;
  localparam int WORD_W = WEIGHTS_PER_NODE * WEIGHT_WIDTH;
  localparam logic [BEAT_W-1:0]           LAST_BEAT = BEAT_W'(WEIGHTS_PER_NODE - 1);
  localparam logic [RELU_INDEX_WIDTH-1:0] LAST_NODE = RELU_INDEX_WIDTH'(RELU_NODES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSEMBLE,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [RELU_INDEX_WIDTH-1:0] node_q, node_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [WORD_W-1:0]           word_q, word_d;
  logic                        rdy_q, busy_q, done_q, we_q;
  logic                        abort_act;
  logic                        beat_fire;

  assign abort_act = abort && (state_q != ST_IDLE);
  // abort outranks a coincident beat, so the beat is neither stored nor counted
  assign beat_fire = weightValid && rdy_q && !abort;

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    beat_d  = beat_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ASSEMBLE;
          node_d  = '0;
          beat_d  = '0;
        end
      end
      ST_ASSEMBLE: begin
        if (beat_fire) begin
          for (int k = 0; k < WEIGHTS_PER_NODE; k++) begin
            if (beat_q == BEAT_W'(k)) begin
              word_d[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = weightIn;
            end
          end
          if (beat_q == LAST_BEAT) begin
            state_d = ST_SETUP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (node_q == LAST_NODE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ASSEMBLE;
          node_d  = node_q + 1'b1;
          beat_d  = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d = ST_IDLE;
      node_d  = '0;
      beat_d  = '0;
    end
  end

  // Outputs are flops loaded from the next state so the latch enable never sees decode glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      node_q  <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      rdy_q   <= (state_d == ST_ASSEMBLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      we_q    <= (state_d == ST_WRITE);
    end
  end

  assign weightReady = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign writeEnable = we_q;
  assign NodeSelect  = node_q;
  assign writeIn     = word_q;

`ifdef LAYER2_LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && start) begin
      csum_d = '0;
    end else if (abort_act) begin
      csum_d = '0;
    end else if (beat_fire) begin
      csum_d = csum_q + 16'(weightIn);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule
